pulse_stretcher: RTL and testbench

Output-side counterpart to the key-press pulse generator. It accepts single-cycle event pulses and drives a level output, such as an LED, buzzer or flash enable, high for a fixed number of cycles per event. Each burst is followed by a minimum low gap. Events that arrive during a burst are queued in a saturating counter, and a sticky flag records any events lost to saturation.

---
 rtl/pulse_stretcher.sv | 126 ++++++++++++
 tb/tb_pulse_stretcher.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length high bursts separated by a minimum
// low gap, queueing events that arrive while a burst is in progress.
module pulse_stretcher #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               in,
  output logic                               out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned PendW  = $clog2(MAX_PENDING + 1);

  localparam logic [CntW-1:0]  HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]  GapLoad  = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PendW-1:0] PendMax  = PendW'(MAX_PENDING);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHold = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PendW-1:0] pending_d;
  logic             overflow_d;
  logic             end_burst;
  logic             consumed;
  logic             pend_inc;
  logic             pend_dec;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    overflow_d = overflow;
    end_burst  = 1'b0;
    consumed   = 1'b0;
    pend_inc   = 1'b0;
    pend_dec   = 1'b0;

    case (state_q)
      StIdle: begin
        if (in) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          end_burst = 1'b1;
        end
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          end_burst = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Queued events take precedence over a fresh pulse at the end of a burst.
    if (end_burst) begin
      if (pending != '0) begin
        state_d  = StHold;
        cnt_d    = HoldLoad;
        pend_dec = 1'b1;
      end else if (in) begin
        state_d  = StHold;
        cnt_d    = HoldLoad;
        consumed = 1'b1;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end

    if (in && (state_q != StIdle) && !consumed) begin
      if (pending < PendMax) begin
        pend_inc = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    unique case ({pend_inc, pend_dec})
      2'b10:   pending_d = pending + 1'b1;
      2'b01:   pending_d = pending - 1'b1;
      default: pending_d = pending;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      out      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pending  <= pending_d;
      overflow <= overflow_d;
      out      <= (state_d == StHold);
      busy     <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized bench for pulse_stretcher; the reference tracks only the cycles left in the
// current hold+gap period plus a pending count.
module tb_pulse_stretcher;

  localparam int unsigned Hold = 4;
  localparam int unsigned Gap  = 2;
  localparam int unsigned MaxP = 3;
  localparam int unsigned PW   = $clog2(MaxP + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in  = 1'b0;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  // Reference: cycles remaining in the current burst period, 0 when idle.
  int m_rem  = 0;
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  pulse_stretcher #(
    .HOLD_CYCLES(Hold),
    .GAP_CYCLES (Gap),
    .MAX_PENDING(MaxP)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .in      (in),
    .out     (out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit ev, input bit rst);
    if (rst) begin
      m_rem  = 0;
      m_pend = 0;
      m_ovf  = 1'b0;
    end else if (m_rem == 0) begin
      if (ev) m_rem = Hold + Gap;
    end else if (m_rem == 1) begin
      if (m_pend > 0) begin
        m_rem = Hold + Gap;
        if (ev) begin
          if (m_pend < MaxP) m_pend++;
          else m_ovf = 1'b1;
        end
        m_pend--;
      end else if (ev) begin
        m_rem = Hold + Gap;
      end else begin
        m_rem = 0;
      end
    end else begin
      m_rem--;
      if (ev) begin
        if (m_pend < MaxP) m_pend++;
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string phase);
    check_val({phase, ".out"},      int'(out),      int'(m_rem > Gap));
    check_val({phase, ".busy"},     int'(busy),     int'(m_rem != 0));
    check_val({phase, ".pending"},  int'(pending),  m_pend);
    check_val({phase, ".overflow"}, int'(overflow), int'(m_ovf));
  endtask

  // Applies one edge with the given inputs, then samples 1 time unit later.
  task automatic cycle(input bit ev, input bit rst, input string phase);
    RST = rst;
    in  = ev;
    @(posedge CLK);
    model_step(ev, rst);
    #1;
    check_all(phase);
  endtask

  initial begin
    int rate;
    bit ev;
    bit rst;

    // Reset held with in asserted must not start a burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, "reset");
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, "post_reset");

    // Directed burst: pulse into an idle block, then a pulse on the final gap cycle.
    cycle(1'b1, 1'b0, "single");
    for (int i = 0; i < Hold + Gap - 1; i++) cycle(1'b0, 1'b0, "single");
    cycle(1'b1, 1'b0, "final_gap");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, "final_gap");

    // Directed saturation: pulses every cycle until overflow, then drain.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, "overflow");
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, "drain");

    // Reset mid-burst discards queued events.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "mid_burst");
    cycle(1'b0, 1'b1, "mid_reset");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, "after_reset");

    // Random segments with varying event density and rare resets.
    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 4)
        0:       rate = 2;
        1:       rate = 5;
        2:       rate = 12;
        default: rate = 1;
      endcase
      for (int i = 0; i < 200; i++) begin
        ev  = ($urandom_range(rate - 1, 0) == 0);
        rst = ($urandom_range(149, 0) == 0);
        cycle(ev, rst, "random");
      end
    end

    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
